// File: rtl/ltssm_pkg.sv
// ltssm_pkg: shared LTSSM state encodings, ordered-set type codes, PAD symbol and port-type constants
package ltssm_pkg;
  typedef enum logic [3:0] {
    DetectQuiet                 = 4'h0,
    DetectActive                = 4'h1,
    PollingActive               = 4'h2,
    PollingConfigration         = 4'h3,
    ConfigrationLinkWidthStart  = 4'h4,
    ConfigrationLinkWidthAccept = 4'h5,
    ConfigrationLaneNumWait     = 4'h6,
    ConfigrationLaneNumActive   = 4'h7,
    ConfigrationComplete        = 4'h8,
    ConfigrationIdle            = 4'h9,
    L0                          = 4'hA,
    Idle                        = 4'hF
  } ltssmState_e;
  localparam logic [2:0] OsTS1 = 3'd0, OsTS2 = 3'd1, OsIDLE = 3'd4;
  localparam logic [7:0] PAD = 8'hF7;
  localparam bit DownStream = 1'b0, UpStream = 1'b1;
endpackage

// File: rtl/rx_ltssm_if.sv
// rx_ltssm_if: link between the main LTSSM / RX OS decoder (master) and the RX LTSSM slice (slave)
//   master drives: SetRXState, OSValid, OSType, RxLinkNumber, RxLaneNumber, ReadLinkNum
//   slave drives:  RXFinishFlag, RXExitTo, WriteLinkNum, WriteLinkNumFlag
interface rx_ltssm_if;
  logic [3:0] SetRXState;
  logic       RXFinishFlag;
  logic [3:0] RXExitTo;
  logic       OSValid;
  logic [2:0] OSType;
  logic [7:0] RxLinkNumber;
  logic [7:0] RxLaneNumber;
  logic [7:0] ReadLinkNum;
  logic [7:0] WriteLinkNum;
  logic       WriteLinkNumFlag;
  modport master(output SetRXState, OSValid, OSType, RxLinkNumber, RxLaneNumber, ReadLinkNum,
                 input RXFinishFlag, RXExitTo, WriteLinkNum, WriteLinkNumFlag);
  modport slave(input SetRXState, OSValid, OSType, RxLinkNumber, RxLaneNumber, ReadLinkNum,
                output RXFinishFlag, RXExitTo, WriteLinkNum, WriteLinkNumFlag);
endinterface

// File: rtl/rx_os_counter.sv
// rx_os_counter: consecutive matching-OS counter
//   Pclk, Reset: clock and sync active-high reset
//   Clear: restart from zero (state entry); OSValid/Match: OS present and qualifying
//   Target: consecutive count needed; Hit: this OS completes the count (combinational)
module rx_os_counter (
  input  logic       Pclk,
  input  logic       Reset,
  input  logic       Clear,
  input  logic       OSValid,
  input  logic       Match,
  input  logic [3:0] Target,
  output logic       Hit
);
  logic [3:0] Count;
  always_ff @(posedge Pclk) begin
    if (Reset || Clear) Count <= 4'd0;
    else if (OSValid) Count <= Match ? ((Count == 4'hF) ? Count : Count + 4'd1) : 4'd0;
  end
  assign Hit = OSValid && Match && (Count + 4'd1 == Target);
endmodule

// File: rtl/rx_ltssm.sv
// rx_ltssm: receive-side LTSSM slice; counts consecutive qualifying ordered sets or times out
//   in the state commanded by the main LTSSM and reports the exit target
//   Pclk, Reset: clock and sync active-high reset
//   bus (slave): SetRXState/OS inputs in, RXFinishFlag/RXExitTo and link-number write out
module rx_ltssm
  import ltssm_pkg::*;
#(
  parameter bit          DEVICETYPE   = DownStream,
  parameter logic [23:0] TIMEOUT_24MS = 24'd1000,
  parameter logic [23:0] TIMEOUT_2MS  = 24'd100
) (
  input logic Pclk,
  input logic Reset,
  rx_ltssm_if.slave bus
);
  ltssmState_e State, Next;
  logic [23:0] Timer, Limit;
  logic [3:0]  Target;
  logic        Match, Hit, Done, Entry, Timed, CountHit, TimeHit, Fire;
  logic        isTS1, isTS2, isIDLE, linkOk;
  assign isTS1  = bus.OSType == OsTS1;
  assign isTS2  = bus.OSType == OsTS2;
  assign isIDLE = bus.OSType == OsIDLE;
  assign linkOk = bus.RxLinkNumber == bus.ReadLinkNum;
  assign Entry  = bus.SetRXState != State;
  always_comb begin
    Match = 1'b0;
    Target = 4'd0;
    Limit = 24'd0;
    Next = DetectQuiet;
    case (State)
      PollingActive:               begin Match = isTS1 || isTS2; Target = 4'd8; Limit = TIMEOUT_24MS; Next = PollingConfigration; end
      PollingConfigration:         begin Match = isTS2; Target = 4'd8; Limit = TIMEOUT_24MS; Next = ConfigrationLinkWidthStart; end
      ConfigrationLinkWidthStart:  begin Match = isTS1 && bus.RxLinkNumber != PAD; Target = 4'd2; Limit = TIMEOUT_24MS; Next = ConfigrationLinkWidthAccept; end
      ConfigrationLinkWidthAccept: begin Match = isTS1 && linkOk; Target = 4'd2; Limit = TIMEOUT_24MS; Next = ConfigrationLaneNumWait; end
      ConfigrationLaneNumWait:     begin Match = isTS1 && linkOk && bus.RxLaneNumber != PAD; Target = 4'd2; Limit = TIMEOUT_24MS; Next = ConfigrationLaneNumActive; end
      ConfigrationLaneNumActive:   begin Match = isTS2 && linkOk; Target = 4'd2; Limit = TIMEOUT_24MS; Next = ConfigrationComplete; end
      ConfigrationComplete:        begin Match = isTS2 && linkOk; Target = 4'd8; Limit = TIMEOUT_2MS; Next = ConfigrationIdle; end
      ConfigrationIdle:            begin Match = isIDLE; Target = 4'd8; Limit = TIMEOUT_2MS; Next = L0; end
      default: ;
    endcase
  end
  rx_os_counter uCounter (
    .Pclk(Pclk), .Reset(Reset), .Clear(Entry), .OSValid(bus.OSValid),
    .Match(Match), .Target(Target), .Hit(Hit)
  );
  // untimed states carry a zero limit; entry cycles and a finished state never fire
  assign Timed    = |Limit;
  assign CountHit = Hit && !Entry && !Done;
  assign TimeHit  = Timed && !Entry && !Done && Timer == Limit;
  assign Fire     = CountHit || TimeHit;
  always_ff @(posedge Pclk) begin
    if (Reset) begin
      State <= Idle;
      Timer <= 24'd0;
      Done <= 1'b0;
      bus.RXFinishFlag <= 1'b0;
      bus.RXExitTo <= DetectQuiet;
      bus.WriteLinkNum <= 8'd0;
      bus.WriteLinkNumFlag <= 1'b0;
    end else begin
      State <= ltssmState_e'(bus.SetRXState);
      Timer <= Entry ? 24'd0 : (Timed && !Done) ? Timer + 24'd1 : Timer;
      Done <= !Entry && (Done || Fire);
      bus.RXFinishFlag <= Fire;
      // count completion takes priority over a coincident timeout
      if (Fire) bus.RXExitTo <= CountHit ? Next : DetectQuiet;
      bus.WriteLinkNumFlag <= CountHit && State == ConfigrationLinkWidthStart && DEVICETYPE == UpStream;
      if (CountHit && State == ConfigrationLinkWidthStart && DEVICETYPE == UpStream) bus.WriteLinkNum <= bus.RxLinkNumber;
    end
  end
endmodule
